// File: rtl/osd_timestamp_ctrl.sv
// Timestamp counter controller: command-driven run/stop/clear sequencing, prescaled
// counter enable, epoch (wrap) tracking and round-robin capture of {id, epoch, timestamp}.
module osd_timestamp_ctrl #(
  parameter int WIDTH      = 16,
  parameter int NREQ       = 4,
  parameter int PRESCALE_W = 8,
  parameter int EPOCH_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PRESCALE_W-1:0]   cfg_prescale,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  output logic                    ts_enable,
  output logic                    ts_clear,
  input  logic [WIDTH-1:0]        ts_value,
  output logic                    running,
  output logic                    ts_wrap,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic [EPOCH_W-1:0]      out_epoch,
  output logic [WIDTH-1:0]        out_timestamp
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {STOPPED, RUN, CLEARING} state_t;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_START = 2'b01, OP_STOP = 2'b10, OP_CLEAR = 2'b11} op_t;

  state_t                state, state_n;
  logic                  ret, ret_n;
  logic                  clear_n;
  logic                  cmd_fire;
  logic                  wrap_hit;
  logic [PRESCALE_W-1:0] cnt;
  logic [EPOCH_W-1:0]    epoch;
  logic [IDW-1:0]        ptr;
  logic [IDW-1:0]        win;
  logic                  grant;
  logic                  slot_free;
  int unsigned           idx;

  assign cmd_ready = (state != CLEARING);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign ts_enable = (state == RUN) && (cnt == cfg_prescale);
  assign running   = (state == RUN) || ((state == CLEARING) && ret);
  assign wrap_hit  = ts_enable && (ts_value == '1);

  always_comb begin
    state_n = state;
    ret_n   = ret;
    clear_n = 1'b0;
    case (state)
      STOPPED, RUN: begin
        if (cmd_fire) begin
          case (op_t'(cmd_op))
            OP_START: state_n = RUN;
            OP_STOP:  state_n = STOPPED;
            OP_CLEAR: begin
              state_n = CLEARING;
              ret_n   = (state == RUN);
              clear_n = 1'b1;
            end
            default:  state_n = state;
          endcase
        end
      end
      CLEARING: state_n = ret ? RUN : STOPPED;
      default:  state_n = STOPPED;
    endcase
  end

  // Lowering cfg_prescale below cnt lets cnt run up and wrap at PRESCALE_W before matching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STOPPED;
      ret      <= 1'b0;
      ts_clear <= 1'b0;
      ts_wrap  <= 1'b0;
      cnt      <= '0;
      epoch    <= '0;
    end else begin
      state    <= state_n;
      ret      <= ret_n;
      ts_clear <= clear_n;
      ts_wrap  <= wrap_hit;
      if (clear_n) begin
        cnt   <= '0;
        epoch <= '0;
      end else begin
        if (state == RUN)
          cnt <= (cnt == cfg_prescale) ? '0 : cnt + PRESCALE_W'(1);
        if (wrap_hit)
          epoch <= epoch + EPOCH_W'(1);
      end
    end
  end

  always_comb begin
    slot_free = !out_valid || out_ready;
    grant     = 1'b0;
    win       = '0;
    req_ready = '0;
    idx       = 0;
    if (slot_free) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        idx = 32'(ptr) + i;
        if (idx >= 32'(NREQ))
          idx = idx - 32'(NREQ);
        if (!grant && req_valid[idx[IDW-1:0]]) begin
          grant = 1'b1;
          win   = idx[IDW-1:0];
        end
      end
    end
    if (grant)
      req_ready[win] = 1'b1;
  end

  // Capture uses this cycle's ts_value/epoch, i.e. values before any clear or wrap update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      out_valid     <= 1'b0;
      out_id        <= '0;
      out_epoch     <= '0;
      out_timestamp <= '0;
    end else if (grant) begin
      out_valid     <= 1'b1;
      out_id        <= win;
      out_epoch     <= epoch;
      out_timestamp <= ts_value;
      ptr           <= (32'(win) == 32'(NREQ - 1)) ? '0 : win + IDW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
